// File: rtl/imem_stream_loader.sv
// ---------------------------------------------------------------------------
// imem_stream_loader
//
// Streams a program into the byte-wide MIPS instruction memory and then
// sequences the CPU out of reset. Instruction words arrive on a valid/ready
// stream and are written big-endian (most significant byte at the lowest
// address), one byte per clock. Words that would run past the end of the
// memory are accepted and discarded, and this is flagged on `overflow`. Once
// the last word has been written, the CPU reset is held for SETTLE_CYCLES.
// The CPU is then released for one cycle with enable low, and after that it
// is enabled, either indefinitely (RUN_CYCLES = 0) or for exactly RUN_CYCLES
// cycles.
//
// Parameters
//   ADDR_WIDTH    byte address width of the instruction memory
//   DATA_WIDTH    stream word width, a multiple of 8 (BPW = DATA_WIDTH/8)
//   BASE_ADDR     first byte address written, BPW-aligned
//   SETTLE_CYCLES cycles cpu_rst_n stays low after the last write (>= 1)
//   RUN_CYCLES    CPU enable budget in cycles, 0 = unlimited
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   start         one-cycle pulse; begins a load from IDLE, RUN or HALT
//   s_valid/s_ready/s_data/s_last   instruction word stream
//   mem_we/mem_addr/mem_wdata       instruction memory byte write port
//   cpu_rst_n, cpu_enable           CPU control
//   load_done     high from SETTLE entry until the next load or reset
//   run_done      high while halted after the run budget expires
//   overflow      sticky: a word was dropped beyond the memory end
//   words_loaded  number of words actually written in this load
// ---------------------------------------------------------------------------
module imem_stream_loader #(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 32,
  parameter int BASE_ADDR     = 0,
  parameter int SETTLE_CYCLES = 4,
  parameter int RUN_CYCLES    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  cpu_enable,
  output logic                  load_done,
  output logic                  run_done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;
  // The pointer carries one extra bit so that it can point one past the
  // final byte (a completely full memory) without wrapping back to zero.
  localparam int PW  = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] BASE_P      = PW'(BASE_ADDR);
  localparam logic [PW:0]   MEM_BYTES   = (PW+1)'(1) << ADDR_WIDTH;
  localparam logic [KW-1:0] K_LAST      = KW'(BPW - 1);
  localparam logic [31:0]   SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]   RUN_LAST    = 32'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_SETTLE,
    S_RELEASE,
    S_RUN,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]         ptr_q;
  logic [KW-1:0]         k_q;
  logic [31:0]           cnt_q;
  logic [PW-1:0]         words_q;
  logic                  ovf_q;

  // Captured stream word (stage p0: between handshake and byte writes).
  logic [DATA_WIDTH-1:0] word_p0;
  logic                  last_p0;
  logic                  drop_p0;

  logic                  load_init;
  logic                  handshake;
  logic                  word_end;
  logic                  too_far;

  // Byte lane k of a word, counted from the most significant end.
  function automatic logic [7:0] byte_lane(input logic [DATA_WIDTH-1:0] w,
                                           input logic [KW-1:0]         idx);
    logic [DATA_WIDTH-1:0] sh;
    sh = w << {idx, 3'b000};
    return sh[DATA_WIDTH-1 -: 8];
  endfunction

  // Next state, strobes and decoded outputs.
  always_comb begin
    state_d      = state_q;
    load_init    = 1'b0;
    handshake    = 1'b0;
    word_end     = 1'b0;
    s_ready      = 1'b0;
    mem_we       = 1'b0;
    cpu_rst_n    = 1'b0;
    cpu_enable   = 1'b0;
    load_done    = 1'b0;
    run_done     = 1'b0;
    mem_addr     = ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k_q);
    mem_wdata    = byte_lane(word_p0, k_q);
    overflow     = ovf_q;
    words_loaded = words_q;
    // A word fits only if all of its bytes lie below the memory end.
    too_far      = ({1'b0, ptr_q} + (PW+1)'(BPW)) > MEM_BYTES;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ACCEPT;
          load_init = 1'b1;
        end
      end
      S_ACCEPT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_d   = S_WRITE;
          handshake = 1'b1;
        end
      end
      S_WRITE: begin
        mem_we = ~drop_p0;
        if (k_q == K_LAST) begin
          word_end = 1'b1;
          state_d  = last_p0 ? S_SETTLE : S_ACCEPT;
        end
      end
      S_SETTLE: begin
        load_done = 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        load_done = 1'b1;
        cpu_rst_n = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        load_done  = 1'b1;
        cpu_rst_n  = 1'b1;
        cpu_enable = 1'b1;
        if (start) begin
          state_d   = S_ACCEPT;
          load_init = 1'b1;
        end else if (RUN_CYCLES != 0 && cnt_q == RUN_LAST) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        load_done = 1'b1;
        cpu_rst_n = 1'b1;
        run_done  = 1'b1;
        if (start) begin
          state_d   = S_ACCEPT;
          load_init = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE_P;
      k_q     <= '0;
      cnt_q   <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      last_p0 <= 1'b0;
      drop_p0 <= 1'b0;
    end else begin
      state_q <= state_d;

      // The shared cycle counter restarts on every state change, so it
      // measures time spent in SETTLE and in RUN.
      if (state_d != state_q) cnt_q <= '0;
      else                    cnt_q <= cnt_q + 32'd1;

      if (load_init) begin
        ptr_q   <= BASE_P;
        words_q <= '0;
        ovf_q   <= 1'b0;
      end

      if (handshake) begin
        last_p0 <= s_last;
        // Once a word has been dropped, every later word in the load is
        // dropped too, even if it would otherwise fit.
        drop_p0 <= ovf_q | too_far;
        k_q     <= '0;
      end else if (state_q == S_WRITE) begin
        k_q <= k_q + KW'(1);
      end

      if (word_end) begin
        if (drop_p0) begin
          ovf_q <= 1'b1;
        end else begin
          ptr_q   <= ptr_q + PW'(BPW);
          words_q <= words_q + PW'(1);
        end
      end
    end
  end

  // Stage p0 data capture (no reset on data).
  always_ff @(posedge clk) begin
    if (handshake) word_p0 <= s_data;
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;

  localparam int AW     = 11;
  localparam int DW     = 32;
  localparam int BPW    = 4;
  localparam int SETTLE = 4;
  localparam int RUN    = 2500;
  localparam int MEMB   = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_rst_n;
  logic          cpu_enable;
  logic          load_done;
  logic          run_done;
  logic          overflow;
  logic [AW:0]   words_loaded;

  imem_stream_loader #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .BASE_ADDR    (0),
    .SETTLE_CYCLES(SETTLE),
    .RUN_CYCLES   (RUN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_enable  (cpu_enable),
    .load_done   (load_done),
    .run_done    (run_done),
    .overflow    (overflow),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  img[MEMB];
  int  ref_img[MEMB];
  int  saved_img[MEMB];
  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  we_cnt = 0;
  int  bad_ready = 0;
  int  last_we_cyc = 0;
  int  start_cyc = 0;
  int  ld_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every byte write is matched against the scoreboard queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        we_cnt++;
        last_we_cyc = cyc;
        if (s_ready) bad_ready++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
        img[mem_addr] = mem_wdata;
      end
    end
  end

  // Reference model: word n of a load lands at bytes 4n..4n+3, MSB first,
  // as long as the whole word lies inside the memory.
  task automatic model_word(input int n, input logic [31:0] w);
    wr_t e;
    if ((n + 1) * BPW <= MEMB) begin
      for (int b = 0; b < BPW; b++) begin
        e.addr = n * BPW + b;
        e.data = int'((w >> (24 - 8 * b)) & 32'hFF);
        exp_q.push_back(e);
        ref_img[e.addr] = e.data;
      end
    end
  endtask

  task automatic clear_images();
    for (int i = 0; i < MEMB; i++) begin
      img[i] = -1;
      ref_img[i] = -1;
    end
  endtask

  task automatic compare_img(input string name, input int hi);
    int mism = 0;
    for (int i = 0; i < hi; i++) if (img[i] != ref_img[i]) mism++;
    check(name, mism, 0);
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that starts the load.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Called and returns #1 after a posedge. Leaves s_valid high.
  task automatic send_word(input logic [31:0] w, input bit last, input int gap,
                           input bit stray, inout int n);
    int t = 0;
    if (gap > 0) s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (g == 0 && stray) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = w;
    s_last  = last;
    while (!s_ready) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 200) begin
        $display("FAIL handshake_timeout: got %0d cycles, expected at most 200", t);
        $fatal(1, "stream stalled");
      end
    end
    model_word(n, w);
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic finish_load(input bit run_full, input int exp_words, input bit exp_ovf);
    int t = 0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    while (!load_done) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        $display("FAIL load_done_timeout: got %0d cycles, expected at most 100", t);
        $fatal(1, "load never completed");
      end
    end
    ld_cyc = cyc;
    if (!exp_ovf) check("load_done_after_last_write", ld_cyc - last_we_cyc, 1);
    check("words_loaded", words_loaded, exp_words);
    check("overflow", overflow, exp_ovf);
    check("scoreboard_drained", exp_q.size(), 0);
    t = 0;
    while (!cpu_rst_n && t < 50) begin
      t++;
      @(negedge clk);
    end
    check("settle_len", t, SETTLE);
    check("release_enable_low", cpu_enable, 0);
    @(negedge clk);
    check("run_enable", cpu_enable, 1);
    check("run_rst_n", cpu_rst_n, 1);
    if (run_full) begin
      t = 0;
      while (cpu_enable && t < 3000) begin
        t++;
        @(negedge clk);
      end
      check("run_len", t, RUN);
      check("halt_run_done", run_done, 1);
      check("halt_rst_n", cpu_rst_n, 1);
      check("halt_load_done", load_done, 1);
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog_a[3] = '{32'h20080005, 32'h20090000, 32'h01094020};
  logic [7:0]  bytes_a[12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09,
                               8'h00, 8'h00, 8'h01, 8'h09, 8'h40, 8'h20};
  logic [31:0] prog_b[20];

  initial begin
    int n;
    int seen_ready;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    clear_images();
    repeat (3) @(posedge clk);
    #1;

    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_cpu_enable", cpu_enable, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_load_done", load_done, 0);
    check("rst_run_done", run_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_words_loaded", words_loaded, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three-word program, valid held high, full run budget.
    we_cnt = 0; bad_ready = 0; n = 0;
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(prog_a[i], i == 2, 0, 1'b0, n);
    finish_load(1'b1, 3, 1'b0);
    check("load_cycles", ld_cyc - start_cyc, 15);
    check("we_cycles", we_cnt, 12);
    check("ready_during_write", bad_ready, 0);
    begin
      int mism = 0;
      for (int i = 0; i < 12; i++) if (img[i] != int'(bytes_a[i])) mism++;
      check("program_a_bytes", mism, 0);
    end

    // Restart from HALT, 20 random words, no gaps.
    for (int i = 0; i < 20; i++) prog_b[i] = $urandom;
    clear_images(); n = 0;
    pulse_start();
    check("restart_run_done", run_done, 0);
    check("restart_rst_n", cpu_rst_n, 0);
    check("restart_load_done", load_done, 0);
    check("restart_words", words_loaded, 0);
    check("restart_ready", s_ready, 1);
    for (int i = 0; i < 20; i++) send_word(prog_b[i], i == 19, 0, 1'b0, n);
    finish_load(1'b0, 20, 1'b0);
    compare_img("image_b", 80);
    for (int i = 0; i < MEMB; i++) saved_img[i] = img[i];

    // Restart from RUN, same program with gaps and stray start pulses.
    clear_images(); n = 0;
    pulse_start();
    check("run_restart_enable", cpu_enable, 0);
    check("run_restart_rst_n", cpu_rst_n, 0);
    check("run_restart_ready", s_ready, 1);
    for (int i = 0; i < 20; i++)
      send_word(prog_b[i], i == 19, $urandom_range(0, 7), ($urandom_range(0, 3) == 0), n);
    finish_load(1'b0, 20, 1'b0);
    compare_img("image_b_gaps", 80);
    begin
      int mism = 0;
      for (int i = 0; i < 80; i++) if (img[i] != saved_img[i]) mism++;
      check("image_gaps_vs_gapfree", mism, 0);
    end

    // Reset on the second byte of a word.
    clear_images(); n = 0;
    pulse_start();
    send_word($urandom, 1'b0, 0, 1'b0, n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("midrst_mem_we", mem_we, 0);
    check("midrst_rst_n", cpu_rst_n, 0);
    check("midrst_ready", s_ready, 0);
    check("midrst_words", words_loaded, 0);
    rst = 1'b0;
    s_valid = 1'b1;
    seen_ready = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (s_ready) seen_ready++;
    end
    check("idle_ignores_valid", seen_ready, 0);
    s_valid = 1'b0;

    // Reload after reset starts again from the base address.
    clear_images(); n = 0;
    pulse_start();
    for (int i = 0; i < 3; i++) send_word($urandom, i == 2, $urandom_range(0, 3), 1'b0, n);
    finish_load(1'b0, 3, 1'b0);
    compare_img("image_after_reset", 12);

    // Overflow: 514 words into a 512-word memory.
    clear_images(); n = 0;
    pulse_start();
    for (int i = 0; i < 514; i++) send_word($urandom, i == 513, $urandom_range(0, 1), 1'b0, n);
    finish_load(1'b0, 512, 1'b1);
    compare_img("image_overflow", MEMB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Parametrised program loader for the MIPS CPU. It replaces the back-door `$readmemb` load of the byte-wide instruction memory with a synthesizable streaming path.
- Accepts instruction words on a valid/ready stream and writes them big-endian, one byte per cycle, into the byte-addressed instruction memory.
- Sequences the CPU's reset release and `enable`.
- Optionally bounds the run to a fixed cycle budget, so bench and FPGA bring-up share one loader.

Parameters:
- ADDR_WIDTH, 11, byte address width of the instruction memory (2048 bytes).
- DATA_WIDTH, 32, stream word width; must be a multiple of 8. BPW = DATA_WIDTH/8.
- BASE_ADDR, 0, first byte address written; must be BPW-aligned.
- SETTLE_CYCLES, 4, cycles `cpu_rst_n` stays low after the last byte write (minimum 1).
- RUN_CYCLES, 0, CPU enable budget in cycles; 0 = unlimited.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, single-cycle pulse that begins a load.
- s_valid, input, 1, stream word valid.
- s_ready, output, 1, loader can accept a word.
- s_data, input, DATA_WIDTH, instruction word.
- s_last, input, 1, marks the final word of the program.
- mem_we, output, 1, instruction-memory byte write enable.
- mem_addr, output, ADDR_WIDTH, byte address.
- mem_wdata, output, 8, byte data.
- cpu_rst_n, output, 1, active-low reset to the CPU.
- cpu_enable, output, 1, CPU enable.
- load_done, output, 1, high from SETTLE entry until the next load starts or reset.
- run_done, output, 1, high in HALT.
- overflow, output, 1, sticky: at least one word was dropped beyond the memory end.
- words_loaded, output, ADDR_WIDTH+1, count of words actually written.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - `cpu_rst_n`=0; every other output=0.
  - Byte pointer `ptr`=BASE_ADDR.
  - Applies in any state. Bytes already written are not undone. `mem_we` is low from the cycle after the reset edge.
- States: IDLE, ACCEPT, WRITE, SETTLE, RELEASE, RUN, HALT.
- IDLE:
  - `s_ready`=0.
  - `start` → ACCEPT. Same edge: `ptr`=BASE_ADDR, `words_loaded`=0, `overflow`=0, `load_done`=0.
- ACCEPT:
  - `s_ready`=1.
  - A handshake (`s_valid` & `s_ready`) captures `s_data` and `s_last` and goes to WRITE with byte index k=0.
  - A word is marked drop if ptr+BPW > 2^ADDR_WIDTH, or if an earlier word in this load was dropped.
- WRITE:
  - `s_ready`=0.
  - Runs BPW consecutive cycles, k=0..BPW-1.
  - Each cycle: `mem_we`=1 (0 for a dropped word), `mem_addr`=ptr+k, `mem_wdata`=word[DATA_WIDTH-1-8k -: 8] (MSB at the lowest address).
  - After k=BPW-1, for a written word: ptr+=BPW and `words_loaded`+=1.
  - After k=BPW-1, for a dropped word: set `overflow`.
  - Next state is SETTLE if the captured last=1, else ACCEPT.
  - Maximum throughput is one word per BPW+1 cycles.
- SETTLE:
  - `load_done`=1, `cpu_rst_n`=0.
  - Holds SETTLE_CYCLES cycles, then → RELEASE.
- RELEASE:
  - `cpu_rst_n`=1, `cpu_enable`=0 for exactly one cycle, then → RUN.
- RUN:
  - `cpu_rst_n`=1, `cpu_enable`=1. A cycle counter starts at 0.
  - If RUN_CYCLES≠0, `cpu_enable` is high for exactly RUN_CYCLES cycles, then → HALT.
- HALT:
  - `cpu_enable`=0, `cpu_rst_n`=1 (CPU state preserved for inspection), `run_done`=1.
- Restart:
  - `start` in RUN or HALT → ACCEPT. Same edge: `cpu_rst_n`=0, `cpu_enable`=0, `run_done`=0, plus the IDLE→ACCEPT initialisation.
  - `start` is ignored in ACCEPT, WRITE, SETTLE and RELEASE.
- Stream rules:
  - `s_data` and `s_last` are sampled only on a handshake. `s_valid` may drop at any time.
  - A single-word program (`s_last` on the first word) is legal.
- Overflow:
  - Once overflow is detected, every remaining word up to `s_last` is accepted and dropped.
  - The load still completes, the CPU is still released, and `overflow` stays 1 until the next `start` or `rst`.

Test Plan:
1. ADDR_WIDTH=11, BASE=0, stream 0x20080005, 0x20090000, 0x01094020 (last) with `s_valid` held high → bytes 0..11 = 20 08 00 05 20 09 00 00 01 09 40 20. `mem_we` is high in 12 of 15 cycles and `s_ready` is low during every WRITE cycle. `words_loaded`=3 and `overflow`=0.
2. SETTLE_CYCLES=4 with scenario 1 → `load_done` rises the cycle after the last byte write. `cpu_rst_n` rises exactly 4 cycles later and `cpu_enable` exactly 1 cycle after that.
3. RUN_CYCLES=2500 → `cpu_enable` high for exactly 2500 cycles, then `cpu_enable`=0, `run_done`=1, `cpu_rst_n` stays 1.
4. ADDR_WIDTH=4 (16 bytes), stream 5 words → bytes 0..15 hold words 1-4 and `mem_we` never fires for word 5. `overflow`=1, `words_loaded`=4, and the CPU is still released.
5. `s_valid` with random gaps of 0-7 cycles, plus `start` pulsed mid-load → memory image identical to the gap-free case, and the mid-load `start` has no effect.
6. `rst` asserted on the WRITE cycle with k=1 → next cycle `mem_we`=0, `cpu_rst_n`=0, state IDLE. A subsequent `start` reloads from BASE_ADDR. A `start` pulsed in RUN restarts the load with `cpu_enable` dropping on the same edge.
